// File: rtl/mux4_sel_arbiter_if.sv
// mux4_sel_arbiter_if
//   Bundles the request/accept handshake between the requesters, the
//   arbiter and the mux4_1 select path.
//   req   [3:0]  per-channel request (bit i -> mux input a/b/c/d)
//   ready        downstream accepts the current selection
//   sel   [1:0]  registered mux select
//   gnt   [3:0]  registered one-hot grant (0 while not valid)
//   valid        sel holds a granted channel
//   master : requester/downstream side (drives req, ready)
//   slave  : arbiter side (drives sel, gnt, valid)
interface mux4_sel_arbiter_if;
    logic [3:0] req;
    logic       ready;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;

    modport master (output req, output ready, input sel, input gnt, input valid);
    modport slave  (input req, input ready, output sel, output gnt, output valid);
endinterface

// File: rtl/mux4_sel_arbiter.sv
// mux4_sel_arbiter
//   Round-robin arbiter producing the select for a mux4_1. A grant is
//   sticky until accepted (valid & ready); on accept the search pointer
//   moves past the accepted channel and a new grant is issued in the same
//   cycle if anything is requesting, so grants run back to back.
//   Optional feature: define MUX4_BURST_EN to let the current channel keep
//   the grant for up to BURST_LEN accepted beats while it keeps requesting.
// Ports
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset
//   bus   : mux4_sel_arbiter_if.slave (req, ready in; sel, gnt, valid out)
// Parameters
//   BURST_LEN : max beats per grant, 1-16 (only with MUX4_BURST_EN)
module mux4_sel_arbiter #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mux4_sel_arbiter_if.slave     bus
);
    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t     r_state, w_state_n;
    logic [1:0] r_sel,   w_sel_n;
    logic [3:0] r_gnt,   w_gnt_n;
    logic [1:0] r_ptr,   w_ptr_n;
    logic       w_accept;
`ifdef MUX4_BURST_EN
    logic [3:0] r_cnt,   w_cnt_n;
    logic       w_hold;
`endif

    // First set bit of req searching upward from ptr, modulo 4. Walking
    // the offsets from far to near lets the nearest hit win.
    function automatic logic [1:0] f_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        f_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) f_pick = idx;
        end
    endfunction

    assign w_accept = (r_state == S_GRANT) && bus.ready;

`ifdef MUX4_BURST_EN
    // Same channel keeps the bus while it still requests and the burst
    // has beats left; the count tracks beats already accepted.
    assign w_hold = w_accept && bus.req[r_sel] && (r_cnt < 4'(BURST_LEN - 1));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= 2'b00;
            r_gnt   <= 4'b0000;
            r_ptr   <= 2'b00;
`ifdef MUX4_BURST_EN
            r_cnt   <= 4'd0;
`endif
        end else begin
            r_state <= w_state_n;
            r_sel   <= w_sel_n;
            r_gnt   <= w_gnt_n;
            r_ptr   <= w_ptr_n;
`ifdef MUX4_BURST_EN
            r_cnt   <= w_cnt_n;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        logic [1:0] arb_ptr;
        logic [1:0] pick;
        w_state_n = r_state;
        w_sel_n   = r_sel;
        w_gnt_n   = r_gnt;
        w_ptr_n   = r_ptr;
        arb_ptr   = r_ptr;
        pick      = 2'b00;
`ifdef MUX4_BURST_EN
        w_cnt_n   = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                pick = f_pick(bus.req, r_ptr);
                if (bus.req != 4'b0000) begin
                    w_state_n = S_GRANT;
                    w_sel_n   = pick;
                    w_gnt_n   = 4'b0001 << pick;
                end else begin
                    w_gnt_n   = 4'b0000;
                end
            end
            S_GRANT: begin
                if (w_accept) begin
`ifdef MUX4_BURST_EN
                    if (w_hold) begin
                        w_cnt_n = r_cnt + 4'd1;
                    end else begin
                        w_cnt_n = 4'd0;
`endif
                        // Rotate past the accepted channel, then rearbitrate
                        // on the live req so new requests join immediately.
                        arb_ptr = r_sel + 2'd1;
                        w_ptr_n = arb_ptr;
                        pick    = f_pick(bus.req, arb_ptr);
                        if (bus.req != 4'b0000) begin
                            w_sel_n = pick;
                            w_gnt_n = 4'b0001 << pick;
                        end else begin
                            w_state_n = S_IDLE;
                            w_gnt_n   = 4'b0000;
                        end
`ifdef MUX4_BURST_EN
                    end
`endif
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Outputs come straight from registers
    always_comb begin
        bus.sel   = r_sel;
        bus.gnt   = r_gnt;
        bus.valid = (r_state == S_GRANT);
    end
endmodule

// File: tb/tb_mux4_sel_arbiter.sv
module tb_mux4_sel_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    mux4_sel_arbiter_if bus ();

    mux4_sel_arbiter #(.BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [1:0] sel,
                              input logic [3:0] gnt, input logic valid);
        vectors++;
        if ({bus.sel, bus.gnt, bus.valid} !== {sel, gnt, valid}) begin
            miscompares++;
            $display("FAIL %s: got sel=%0d gnt=%b valid=%b, want sel=%0d gnt=%b valid=%b",
                     name, bus.sel, bus.gnt, bus.valid, sel, gnt, valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = 4'b1111; bus.ready = 1'b1;
        step(); step();
        vectors++;
        if ({bus.sel, bus.gnt, bus.valid} !== {2'd0, 4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got sel=%0d gnt=%b valid=%b, want 0/0000/0",
                     bus.sel, bus.gnt, bus.valid);
        end
        bus.req = 4'b0000; bus.ready = 1'b0; rst = 1'b0;
        step();
        vectors++;
        if ({bus.gnt, bus.valid} !== {4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL idle_after_rst: got gnt=%b valid=%b, want 0000/0", bus.gnt, bus.valid);
        end
    endtask

    // ptr=0: all requesting, accept every cycle -> 0,1,2,3,0
    task automatic test_rotate();
        logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bus.req = 4'b1111; bus.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({bus.sel, bus.gnt, bus.valid} !== {exp_sel[i], 4'b0001 << exp_sel[i], 1'b1}) begin
                miscompares++;
                $display("FAIL rotate[%0d]: got sel=%0d gnt=%b valid=%b, want sel=%0d valid=1",
                         i, bus.sel, bus.gnt, bus.valid, exp_sel[i]);
            end
        end
        bus.req = 4'b0000;
        step();
        vectors++;
        if ({bus.gnt, bus.valid} !== {4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL rotate_idle: got gnt=%b valid=%b, want 0000/0", bus.gnt, bus.valid);
        end
    endtask

    // ptr=1 now. Grant on ch2 held while ready=0, even after req drops.
    task automatic test_sticky();
        bus.req = 4'b0100; bus.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({bus.sel, bus.gnt, bus.valid} !== {2'd2, 4'b0100, 1'b1}) begin
                miscompares++;
                $display("FAIL sticky[%0d]: got sel=%0d gnt=%b valid=%b, want 2/0100/1",
                         i, bus.sel, bus.gnt, bus.valid);
            end
        end
        bus.req = 4'b0000;
        step();
        expect_out("sticky_req_dropped", 2'd2, 4'b0100, 1'b1);
        bus.ready = 1'b1;
        step();
        expect_out("sticky_accept_idle", 2'd2, 4'b0000, 1'b0);
    endtask

    // ptr=3 now.
    task automatic test_wrap();
        bus.req = 4'b0010; bus.ready = 1'b0;
        step();
        expect_out("wrap_grant_ch1", 2'd1, 4'b0010, 1'b1);
        bus.req = 4'b0011; bus.ready = 1'b1;
        step();
        expect_out("wrap_0011_to_0", 2'd0, 4'b0001, 1'b1);
        bus.req = 4'b0010; bus.ready = 1'b1;
        step();
        expect_out("wrap_back_to_ch1", 2'd1, 4'b0010, 1'b1);
        bus.req = 4'b1010; bus.ready = 1'b1;
        step();
        expect_out("wrap_1010_to_3", 2'd3, 4'b1000, 1'b1);
        bus.req = 4'b0000; bus.ready = 1'b0;
        step();
        expect_out("wrap_hold_ch3", 2'd3, 4'b1000, 1'b1);
    endtask

    // Reset while valid=1, sel=3, ready=0.
    task automatic test_rst_mid_grant();
        rst = 1'b1; bus.req = 4'b1000; bus.ready = 1'b0;
        step();
        expect_out("rst_mid_grant", 2'd0, 4'b0000, 1'b0);
        rst = 1'b0;
        step();
        expect_out("rst_regrant_ch3", 2'd3, 4'b1000, 1'b1);
        bus.req = 4'b0000; bus.ready = 1'b1;
        step();
        expect_out("rst_drain", 2'd3, 4'b0000, 1'b0);
    endtask

    task automatic test_back_to_back();
`ifdef MUX4_BURST_EN
        logic [1:0] exp_sel [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
`else
        logic [1:0] exp_sel [8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
        rst = 1'b1; bus.req = 4'b0000; bus.ready = 1'b0;
        step();
        rst = 1'b0; bus.req = 4'b0011; bus.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if ({bus.sel, bus.gnt, bus.valid} !== {exp_sel[i], 4'b0001 << exp_sel[i], 1'b1}) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got sel=%0d gnt=%b valid=%b, want sel=%0d valid=1",
                         i, bus.sel, bus.gnt, bus.valid, exp_sel[i]);
            end
        end
    endtask

    initial begin
        bus.req = 4'b0000; bus.ready = 1'b0;
        test_reset();
        test_rotate();
        test_sticky();
        test_wrap();
        test_rst_mid_grant();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mux4_sel_arbiter.md
MUX4_SEL_ARBITER -- requirements
Module: mux4_sel_arbiter

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 4, meaning the maximum number of consecutive accepted beats granted to one channel (used only when MUX4_BURST_EN is defined; legal range 1-16).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port req  input  4  per-channel request; bit i corresponds to mux4_1 data input a/b/c/d for i=0/1/2/3.
REQ-005 The block SHALL have port ready  input  1  downstream accepts the current selection when valid and ready are both high.
REQ-006 The block SHALL have port sel  output  2  registered select, wired directly to the sel input of mux4_1.
REQ-007 The block SHALL have port gnt  output  4  registered one-hot grant; gnt equals 1<<sel while valid is high, otherwise 0.
REQ-008 The block SHALL have port valid  output  1  registered; high when sel holds a granted channel.

Function
REQ-009 The block SHALL implement a two-state machine: IDLE (valid=0) and GRANT (valid=1).
REQ-010 In IDLE, when req!=0, the block SHALL choose the first set bit of req, searching from ptr upward modulo 4, load sel and gnt, and enter GRANT on the next edge (latency one cycle from req to valid).
REQ-011 In IDLE, when req==0, the block SHALL remain in IDLE with sel unchanged and gnt=0.
REQ-012 In GRANT with ready=0, the block SHALL hold sel, gnt and valid unchanged, even if req[sel] deasserts (grant is sticky until accepted).
REQ-013 On accept (valid&ready), the block SHALL set ptr to sel+1 modulo 4 (wrap 3->0).
REQ-014 On accept with req!=0, the block SHALL re-arbitrate in the same cycle using the updated ptr and stay in GRANT (back-to-back grants, no bubble).
REQ-015 On accept with req==0, the block SHALL enter IDLE, with valid=0 and gnt=0 on the next cycle.
REQ-016 Re-arbitration SHALL consider the current req value only; requests raised in the accept cycle SHALL participate.
REQ-017 With a single requester continuously asserted, the block SHALL grant it on every accept (it wraps back to itself).
REQ-018 gnt SHALL never have more than one bit set.

Reset
REQ-019 While rst=1, the block SHALL force state=IDLE, sel=2'b00, gnt=4'b0000, valid=0, ptr=0 and the burst counter to 0, overriding all other inputs.
REQ-020 rst asserted mid-grant (valid=1, ready=0) SHALL drop the grant without an accept; after release, arbitration SHALL restart from channel 0.
REQ-021 On the first edge after rst deasserts, the block SHALL behave as IDLE.

Configuration
REQ-022 When MUX4_BURST_EN is defined, an accept with req[sel]=1 and beat count < BURST_LEN-1 SHALL keep the same sel, increment the beat count, and leave ptr unchanged.
REQ-023 When MUX4_BURST_EN is defined, reaching BURST_LEN accepted beats or accepting with req[sel]=0 SHALL clear the count and re-arbitrate per REQ-013/014.
REQ-024 When MUX4_BURST_EN is not defined, the block SHALL contain no burst counter, SHALL rotate on every accept, and SHALL ignore BURST_LEN.

Verification
REQ-025 Reset then req=4'b1111 with ready=1: sel sequence 0,1,2,3,0 on consecutive cycles starting one cycle after req; valid stays 1.
REQ-026 req=4'b0100 with ready=0 for 5 cycles, then req=0: sel=2, gnt=4'b0100 and valid=1 hold until ready=1; IDLE one cycle after the accept.
REQ-027 Grant on ch1 pending, then req=4'b0011 at the accept: next sel=0 (ptr wrapped past 1); with req=4'b1010 instead, next sel=3.
REQ-028 rst=1 for one cycle while valid=1, sel=3: next cycle valid=0, sel=0, gnt=0; with req=4'b1000 afterwards, sel=3 one cycle after rst drops.
REQ-029 MUX4_BURST_EN defined, BURST_LEN=4, req=4'b0011, ready=1: sel=0 for 4 beats, then sel=1 for 4 beats; without the macro, sel alternates 0,1,0,1.
